// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store engine.
// Holds the access-size codes, the FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bytes never fault; halves need an even address; word and reserved sizes need word alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return lo[0];
            default:  return |lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane selection and sign/zero extension of a captured bus word.
// Little-endian: byte lane = offset, half lane = offset[1].
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        lane_b = word[7:0];
        case (offset)
            2'b00:   lane_b = word[7:0];
            2'b01:   lane_b = word[15:8];
            2'b10:   lane_b = word[23:16];
            2'b11:   lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        if (offset[1]) begin
            lane_h = word[31:16];
        end else begin
            lane_h = word[15:0];
        end
        case (size)
            MEM_BYTE: result = {{24{sign_ext & lane_b[7]}}, lane_b};
            MEM_HALF: result = {{16{sign_ext & lane_h[15]}}, lane_h};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns an EX/MEM access into a req/ack bus
// transaction, stalls the pipeline meanwhile and returns the aligned load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        RegWr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ReadData,
    output logic        WbRegWr,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        acc;
    logic        mis;
    logic        launch;
    logic        expire;
    logic [7:0]  wait_cnt;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] data;
    logic [1:0]  lane_off;
    logic [1:0]  lane_size;
    logic        lane_signed;
    logic [31:0] aligned;

    assign acc    = MemRead | MemWrite;
    assign mis    = acc & misaligned(MemSize, ALUResult[1:0]);
    assign launch = (state == IDLE) & acc & ~mis;
    // Ack has priority over expiry, so expiry is qualified by ~bus_ack.
    assign expire = (state == WAIT) & ~bus_ack & (wait_cnt == TMO_LAST);

    // Store lane replication and byte enables; loads always read the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WriteData;
        if (MemWrite) begin
            case (MemSize)
                MEM_BYTE: begin
                    st_be    = 4'b0001 << ALUResult[1:0];
                    st_wdata = {4{WriteData[7:0]}};
                end
                MEM_HALF: begin
                    st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{WriteData[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = WriteData;
                end
            endcase
        end else begin
            st_be    = 4'b1111;
            st_wdata = WriteData;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (bus_ack || expire) begin
                    next_state = DONE;
                end else begin
                    next_state = WAIT;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus request, wait counter, data capture and abort flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
            data        <= 32'h0;
            BusErr      <= 1'b0;
            wait_cnt    <= 8'd0;
            lane_off    <= 2'b00;
            lane_size   <= MEM_WORD;
            lane_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    BusErr <= 1'b0;
                    if (launch) begin
                        bus_req     <= 1'b1;
                        bus_we      <= MemWrite;
                        bus_addr    <= {ALUResult[31:2], 2'b00};
                        bus_be      <= st_be;
                        bus_wdata   <= st_wdata;
                        wait_cnt    <= 8'd0;
                        lane_off    <= ALUResult[1:0];
                        lane_size   <= MemSize;
                        lane_signed <= MemSigned;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        data    <= bus_rdata;
                    end else if (expire) begin
                        bus_req <= 1'b0;
                        BusErr  <= 1'b1;
                        data    <= ERR_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    BusErr <= 1'b0;
                default: BusErr <= 1'b0;
            endcase
        end
    end

    load_align u_load_align (
        .word     (data),
        .offset   (lane_off),
        .size     (lane_size),
        .sign_ext (lane_signed),
        .result   (aligned)
    );

    // Pipeline handshake; Stall is forced low while reset is held so the pipeline is released at once.
    always_comb begin
        Stall    = ~reset & (launch | (state == WAIT));
        AddrErr  = mis & (state == IDLE);
        WbRegWr  = RegWr & ~Stall & ~mis & ~((state == DONE) & BusErr & MemRead);
        if ((state == DONE) && BusErr) begin
            ReadData = ERR_DATA;
        end else begin
            ReadData = aligned;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against an arithmetic
// reference model of lane selection, byte enables and handshake timing.
module tb_mem_access_unit;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, MemSigned, RegWr;
    logic [1:0]  MemSize;
    logic [31:0] ALUResult, WriteData;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, ReadData;
    logic [3:0]  bus_be;
    logic        WbRegWr, Stall, AddrErr, BusErr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .ALUResult(ALUResult), .WriteData(WriteData), .RegWr(RegWr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .ReadData(ReadData), .WbRegWr(WbRegWr), .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        case (sz)
            2'b10:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference load result: shift the addressed bytes down, mask, extend.
    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sgn, input logic [31:0] addr);
        int          n;
        int          off;
        logic [63:0] mask;
        logic [63:0] v;
        n    = nbytes_of(sz);
        off  = (n == 4) ? 0 : int'(addr[1:0]);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = ({32'h0, word} >> (8 * off)) & mask;
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic wr, input logic [1:0] sz, input logic [31:0] addr);
        int n;
        n = nbytes_of(sz);
        if (!wr || n == 4) return 4'b1111;
        return 4'(((1 << n) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int          n;
        logic [63:0] w;
        logic [63:0] pat;
        n   = nbytes_of(sz);
        pat = {32'h0, wd} & ((64'd1 << (8 * n)) - 64'd1);
        w   = 64'h0;
        for (int i = 0; i < 4 / n; i++) w = w | (pat << (8 * n * i));
        return w[31:0];
    endfunction

    // One instruction through the MEM stage; ack_at = WAIT cycle carrying the ack (outside 1..TO means never).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                             input int ack_at, input logic [31:0] rdata);
        int   n, k, stalls;
        logic acc, mis, tmo;
        n   = nbytes_of(sz);
        acc = rd | wr;
        mis = acc && ((int'(addr[1:0]) % n) != 0);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn;
        ALUResult = addr; WriteData = wd; RegWr = rw;
        #1;
        if (!acc || mis) begin
            chk("pass_stall", 32'(Stall), 32'(1'b0));
            chk("addr_err", 32'(AddrErr), 32'(mis));
            chk("pass_wb", 32'(WbRegWr), 32'(rw & ~mis));
            @(posedge clk); #1;
            chk("pass_no_req", 32'(bus_req), 32'(1'b0));
            return;
        end
        stalls = Stall ? 1 : 0;
        chk("launch_wb", 32'(WbRegWr), 32'(1'b0));
        chk("launch_req", 32'(bus_req), 32'(1'b0));
        chk("launch_addrerr", 32'(AddrErr), 32'(1'b0));
        @(posedge clk); #1;
        chk("req", 32'(bus_req), 32'(1'b1));
        chk("we", 32'(bus_we), 32'(wr));
        chk("addr", bus_addr, {addr[31:2], 2'b00});
        chk("be", 32'(bus_be), 32'(exp_be(wr, sz, addr)));
        if (wr) chk("wdata", bus_wdata, exp_wdata(sz, wd));
        tmo = 1'b0;
        for (k = 1; k <= TO; k++) begin
            if (Stall) stalls++;
            chk("wait_wb", 32'(WbRegWr), 32'(1'b0));
            if (k == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom();
            if (k == ack_at) break;
            if (k == TO) begin tmo = 1'b1; break; end
            chk("hold_req", 32'(bus_req), 32'(1'b1));
            chk("hold_addr", bus_addr, {addr[31:2], 2'b00});
        end
        chk("stall_cycles", 32'(stalls), 32'(k + 1));
        chk("done_req", 32'(bus_req), 32'(1'b0));
        chk("done_stall", 32'(Stall), 32'(1'b0));
        chk("done_buserr", 32'(BusErr), 32'(tmo));
        chk("done_wb", 32'(WbRegWr), 32'(rw & ~(tmo & rd)));
        if (rd && !wr) begin
            chk("done_rdata", ReadData, tmo ? ERR : exp_load(rdata, sz, sgn, addr));
            last_rd = exp_load(tmo ? ERR : rdata, sz, sgn, addr);
        end
        @(posedge clk); #1;
        chk("idle_buserr", 32'(BusErr), 32'(1'b0));
        if (rd && !wr) chk("hold_rdata", ReadData, last_rd);
    endtask

    initial begin
        logic [1:0]  r_sz;
        logic [31:0] r_addr;
        int          r_op, r_ack, r_sel;
        reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; RegWr = 1'b0; last_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus_req), 32'(1'b0));
        chk("rst_we", 32'(bus_we), 32'(1'b0));
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_buserr", 32'(BusErr), 32'(1'b0));
        chk("rst_rdata", ReadData, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 1, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 1'b1, 1, 32'h80112233);
        chk("lb_signed_const", last_rd, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 1'b1, 2, 32'h80112233);
        chk("lbu_const", last_rd, 32'h00000080);
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 1, 32'h80112233);
        chk("lh_signed_const", last_rd, 32'hFFFF8011);

        // Ack outside WAIT must not disturb the captured data.
        MemRead = 1'b0; MemWrite = 1'b0; RegWr = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("stray_ack_rdata", ReadData, last_rd);
        chk("stray_ack_stall", 32'(Stall), 32'(1'b0));

        do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 1'b0, 1, 32'h0);
        chk("sh_wdata_const", bus_wdata, 32'hABCDABCD);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, 1, 32'h0);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h140, 32'h0, 1'b1, 0, 32'h0);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h144, 32'h0, 1'b1, TO, 32'hCAFEF00D);
        do_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h301, 32'h000000A5, 1'b1, 3, 32'h0);

        // Reset in the 3rd WAIT cycle abandons the transaction at once.
        MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'b00; ALUResult = 32'h300; RegWr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'(1'b0));
        chk("mid_rst_stall", 32'(Stall), 32'(1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h304, 32'h0, 1'b1, 1, 32'h0BADF00D);

        for (int i = 0; i < 40; i++) begin
            r_op  = $urandom_range(0, 3);
            r_sz  = 2'($urandom_range(0, 3));
            r_addr = $urandom();
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(nbytes_of(r_sz) - 1);
            r_sel = $urandom_range(0, 9);
            r_ack = (r_sel == 0) ? 0 : (r_sel == 1) ? TO : $urandom_range(1, 4);
            do_access(r_op[0], r_op[1], r_sz, 1'($urandom_range(0, 1)), r_addr, $urandom(),
                      1'($urandom_range(0, 1)), r_ack, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB register.
- Converts the EX-stage address and store data into a request/acknowledge data-bus transaction with byte enables.
- Stalls the pipeline while a transaction is outstanding.
- Delivers the aligned, extended load result to the MEM/WB ReadData input.
- Suppresses register write-back for bubbles and faulting accesses.

Parameters:
- TIMEOUT, 16, WAIT-state cycles without bus_ack before the access is aborted with BusErr (range 2..255).
- ERR_DATA, 32'h0, value presented on ReadData for an aborted load.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM.
- MemSize  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- MemSigned  in  1  load extension: 1 sign-extend, 0 zero-extend.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data, right-justified.
- RegWr  in  1  write-back enable from EX/MEM.
- bus_req  out  1  request valid, registered.
- bus_we  out  1  1 store, 0 load, registered.
- bus_addr  out  32  word address {ALUResult[31:2],2'b00}, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_ack  in  1  slave completion, one-cycle pulse.
- bus_rdata  in  32  read word, valid with bus_ack.
- ReadData  out  32  aligned/extended load result for MEM/WB.
- WbRegWr  out  1  gated RegWr for MEM/WB.
- Stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- AddrErr  out  1  misaligned access, combinational, valid in IDLE.
- BusErr  out  1  timeout abort, asserted in DONE.

Behaviour:
- Reset values, applied immediately on reset: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, data register=0, BusErr=0, timeout counter=0.
- Access: acc = MemRead|MemWrite.
- Misalignment: mis = acc & ((MemSize==01 & ALUResult[0]) | (MemSize==00/11 & |ALUResult[1:0])). Byte accesses are never misaligned.
- Store byte enables (little-endian):
  - byte: 4'b0001<<ALUResult[1:0], wdata={4{WriteData[7:0]}}.
  - half: ALUResult[1] ? 1100 : 0011, wdata={2{WriteData[15:0]}}.
  - word: 1111, wdata=WriteData.
- Loads drive bus_be=1111.
- FSM:
  - IDLE: if acc & ~mis, latch bus_* (bus_req=1) and go to WAIT. Otherwise stay. If mis, AddrErr=1, no request, stay IDLE.
  - WAIT: bus_req is held at 1 and bus_* are held stable.
    - On bus_ack: capture bus_rdata, drop bus_req, go to DONE.
    - Otherwise, if the counter reaches TIMEOUT-1: drop bus_req, set BusErr, load the data register with ERR_DATA, go to DONE.
  - DONE: one cycle. Clear BusErr, go to IDLE. The pipeline advances on this edge.
- Stall = (IDLE & acc & ~mis) | WAIT. Stall is 0 in DONE.
- Latency: minimum 3 cycles per memory instruction (2 stall cycles with ack on the first WAIT cycle). Non-memory instructions pass with 0 stall.
- ReadData is combinational from the data register using the registered byte offset and size:
  - byte: lane ALUResult[1:0].
  - half: lane ALUResult[1].
  - Sign- or zero-extended per MemSigned.
  - Held from the last capture otherwise.
- WbRegWr = RegWr & ~Stall & ~mis & ~(DONE & BusErr & MemRead).
- Stores aborted by timeout have no architectural recovery; BusErr is the only indication.
- bus_ack while not in WAIT is ignored.
- bus_ack on the same cycle the counter expires: ack wins, no BusErr.
- Reset mid-WAIT: bus_req drops asynchronously and the transaction is abandoned. The slave must tolerate this.
- MemRead and MemWrite both 1: treated as a store.

Decomposition:
- Shared package mem_pkg:
  - MemSize encodings (MEM_WORD=2'b00, MEM_HALF=2'b01, MEM_BYTE=2'b10).
  - FSM state encoding (IDLE, WAIT, DONE).
- Sub-module load_align: combinational lane select plus sign/zero extension (inputs word, offset, size, signed).
- Store lane/byte-enable generation stays inline.

Test Plan:
- Load word: addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF -> Stall high 2 cycles, bus_be=1111, ReadData=0xDEADBEEF in DONE, WbRegWr=1 in DONE.
- Load byte signed: addr 0x103, rdata 0x80112233 -> ReadData 0xFFFFFF80. Zero-extended -> 0x00000080. Half at addr 0x102, signed -> 0xFFFF8011.
- Store half: addr 0x202, WriteData 0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200, WbRegWr=0 while stalled.
- Misaligned word load at 0x101 -> AddrErr=1, bus_req never asserts, Stall=0, WbRegWr=0.
- Slave never acks, TIMEOUT=16 -> bus_req drops after 16 WAIT cycles, BusErr=1 for one cycle, ReadData=ERR_DATA, WbRegWr=0. Repeat with ack on cycle 16 -> normal completion, no BusErr.
- Reset asserted on the 3rd WAIT cycle -> bus_req=0 and Stall=0 immediately. After release, a new load completes normally.
